// File: rtl/msg_serializer.sv
// rtl/msg_serializer.sv - message-to-AXI-Stream serializer, DATA_BYTES per beat, LSB-first
module msg_serializer #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DATA_BYTES    = 8,
  parameter int TKEEP_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [15:0]                msg_length,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic                       msg_error,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [8*DATA_BYTES-1:0]    m_tdata,
  output logic [TKEEP_WIDTH-1:0]     m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       tx_done
);

  localparam int MSG_W     = 8 * MAX_MSG_BYTES;
  localparam int BEAT_W    = 8 * DATA_BYTES;
  localparam int MAX_BEATS = (MAX_MSG_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam int BIDX_W    = $clog2(MAX_BEATS) + 1;
  localparam logic [15:0] MAX_LEN  = 16'(MAX_MSG_BYTES);
  localparam logic [15:0] BEAT_LEN = 16'(DATA_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [MSG_W-1:0]    msg_reg;     // bytes not yet presented, shifted down one beat per handshake
  logic [15:0]         len_reg;     // effective (clamped) length
  logic                err_reg;
  logic                ovf_reg;
  logic [BIDX_W-1:0]   beat_idx;    // index of the beat currently on m_*

  logic [15:0]             eff_len;
  logic                    ovf_in;
  logic [BIDX_W-1:0]       next_idx;
  logic [15:0]             next_rem;
  logic [TKEEP_WIDTH-1:0]  first_keep;
  logic [TKEEP_WIDTH-1:0]  next_keep;
  logic                    first_last;
  logic                    next_last;
  logic                    beat_fire;

  // Byte enables for a beat with rem bytes left in the message (rem >= width gives all ones)
  function automatic logic [TKEEP_WIDTH-1:0] keep_for(input logic [15:0] rem);
    logic [TKEEP_WIDTH-1:0] k;
    k = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) k[i] = (16'(i) < rem);
    return k;
  endfunction

  // Zero every data byte whose keep bit is clear
  function automatic logic [BEAT_W-1:0] mask_data(input logic [BEAT_W-1:0] d,
                                                  input logic [TKEEP_WIDTH-1:0] k);
    logic [BEAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTES; i++) m[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    return m;
  endfunction

  assign ovf_in     = (msg_length > MAX_LEN);
  assign eff_len    = ovf_in ? MAX_LEN : msg_length;
  assign next_idx   = beat_idx + BIDX_W'(1);
  assign next_rem   = len_reg - 16'(next_idx) * BEAT_LEN;
  assign first_keep = keep_for(eff_len);
  assign next_keep  = keep_for(next_rem);
  assign first_last = (eff_len <= BEAT_LEN);
  assign next_last  = (next_rem <= BEAT_LEN);
  assign beat_fire  = m_tvalid & m_tready;
  assign tx_done    = beat_fire & m_tlast & ~rst;

  // Accept a message in IDLE, then present one registered beat at a time until the last handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      msg_ready <= 1'b1;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      msg_reg   <= '0;
      len_reg   <= '0;
      err_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      beat_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (msg_valid) begin
            msg_reg  <= msg_data >> BEAT_W;
            len_reg  <= eff_len;
            err_reg  <= msg_error;
            ovf_reg  <= ovf_in;
            beat_idx <= '0;
            // A zero-length message is swallowed without leaving IDLE
            if (eff_len != 16'd0) begin
              state     <= SEND;
              msg_ready <= 1'b0;
              m_tvalid  <= 1'b1;
              m_tdata   <= mask_data(msg_data[BEAT_W-1:0], first_keep);
              m_tkeep   <= first_keep;
              m_tlast   <= first_last;
              m_tuser   <= first_last & (msg_error | ovf_in);
            end
          end
        end
        SEND: begin
          if (beat_fire) begin
            if (m_tlast) begin
              state     <= IDLE;
              msg_ready <= 1'b1;
              m_tvalid  <= 1'b0;
              m_tdata   <= '0;
              m_tkeep   <= '0;
              m_tlast   <= 1'b0;
              m_tuser   <= 1'b0;
              beat_idx  <= '0;
            end else begin
              beat_idx <= next_idx;
              msg_reg  <= msg_reg >> BEAT_W;
              m_tdata  <= mask_data(msg_reg[BEAT_W-1:0], next_keep);
              m_tkeep  <= next_keep;
              m_tlast  <= next_last;
              m_tuser  <= next_last & (err_reg | ovf_reg);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_serializer.sv
// tb/tb_msg_serializer.sv - self-checking bench for msg_serializer against a queue-based beat model
module tb_msg_serializer;

  logic         clk;
  logic         rst;
  logic         msg_valid;
  logic         msg_ready;
  logic [15:0]  msg_length;
  logic [255:0] msg_data;
  logic         msg_error;
  logic         m_tvalid;
  logic         m_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tlast;
  logic         m_tuser;
  logic         tx_done;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        done;
    int          cyc;
  } beat_t;

  beat_t q[$];     // beats the model still expects, front = beat on the bus now
  beat_t log_q[$]; // beats observed to handshake
  bit    pat[$];
  int    rdy_mode;
  int    n_checks;
  int    n_fail;
  int    cyc;
  bit    post_rst;

  msg_serializer #(.MAX_MSG_BYTES(32), .DATA_BYTES(8), .TKEEP_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_length(msg_length),
    .msg_data(msg_data), .msg_error(msg_error),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Split a message into the beats it must produce, straight from the length/keep rules
  task automatic push_msg(input logic [255:0] vec, input int len, input logic err);
    int    l;
    int    n;
    int    cnt;
    bit    ovf;
    beat_t b;
    ovf = (len > 32);
    l   = ovf ? 32 : len;
    n   = (l + 7) / 8;
    for (int k = 0; k < n; k++) begin
      cnt = l - 8 * k;
      if (cnt > 8) cnt = 8;
      b.data = '0;
      for (int j = 0; j < cnt; j++) b.data[8*j +: 8] = vec[8*(8*k + j) +: 8];
      b.keep = (cnt == 8) ? 8'hFF : 8'((1 << cnt) - 1);
      b.last = (k == n - 1);
      b.user = b.last && (err || ovf);
      b.done = b.last;
      b.cyc  = 0;
      q.push_back(b);
    end
  endtask

  // Compare process: mid-cycle, check outputs against the model, then advance the model
  always @(negedge clk) begin
    beat_t cur;
    cyc++;
    if (rst) begin
      q.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_tdata", m_tdata, 64'h0);
        chk("rst_tkeep", {56'h0, m_tkeep}, 64'h0);
        chk("rst_tlast", {63'h0, m_tlast}, 64'h0);
        chk("rst_tuser", {63'h0, m_tuser}, 64'h0);
        post_rst = 1'b0;
      end
      chk("msg_ready", {63'h0, msg_ready}, {63'h0, q.size() == 0});
      chk("m_tvalid", {63'h0, m_tvalid}, {63'h0, q.size() != 0});
      if (q.size() != 0) begin
        cur = q[0];
        chk("m_tdata", m_tdata, cur.data);
        chk("m_tkeep", {56'h0, m_tkeep}, {56'h0, cur.keep});
        chk("m_tlast", {63'h0, m_tlast}, {63'h0, cur.last});
        chk("m_tuser", {63'h0, m_tuser}, {63'h0, cur.user});
        chk("tx_done", {63'h0, tx_done}, {63'h0, m_tready && cur.last});
        if (m_tready) begin
          cur.done = tx_done;
          cur.cyc  = cyc;
          cur.data = m_tdata;
          cur.keep = m_tkeep;
          cur.last = m_tlast;
          cur.user = m_tuser;
          log_q.push_back(cur);
          void'(q.pop_front());
        end
      end else begin
        chk("idle_tx_done", {63'h0, tx_done}, 64'h0);
        chk("idle_tuser", {63'h0, m_tuser & ~m_tlast}, 64'h0);
        if (msg_valid) push_msg(msg_data, int'(msg_length), msg_error);
      end
    end
  end

  // Downstream ready: random in mode 0, scripted pattern (then 1) in mode 1
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) m_tready = ($urandom % 4) != 0;
      else if (pat.size() != 0 && m_tvalid) m_tready = pat.pop_front();
      else m_tready = 1'b1;
    end
  end

  task automatic send_msg(input int len, input logic [255:0] vec, input logic err);
    int   guard;
    logic acc;
    msg_length = 16'(len);
    msg_data   = vec;
    msg_error  = err;
    msg_valid  = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = msg_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("send_accepted", {63'h0, acc}, 64'h1);
    msg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (q.size() != 0 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("idle_reached", {63'h0, q.size() == 0}, 64'h1);
  endtask

  task automatic chk_beat(input string name, input int idx, input logic [63:0] d,
                          input logic [7:0] k, input logic l, input logic u);
    if (idx >= log_q.size()) begin
      chk({name, "_present"}, 64'(log_q.size()), 64'(idx + 1));
    end else begin
      chk({name, "_data"}, log_q[idx].data, d);
      chk({name, "_keep"}, {56'h0, log_q[idx].keep}, {56'h0, k});
      chk({name, "_last"}, {63'h0, log_q[idx].last}, {63'h0, l});
      chk({name, "_user"}, {63'h0, log_q[idx].user}, {63'h0, u});
      chk({name, "_done"}, {63'h0, log_q[idx].done}, {63'h0, l});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] v;
    int           b;
    int           len;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rdy_mode = 1;
    rst       = 1'b1;
    msg_valid = 1'b0;
    msg_length = '0;
    msg_data   = '0;
    msg_error  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then idle with no message
    chk("reset_msg_ready", {63'h0, msg_ready}, 64'h1);
    chk("reset_tvalid", {63'h0, m_tvalid}, 64'h0);
    chk("reset_tx_done", {63'h0, tx_done}, 64'h0);
    repeat (4) @(posedge clk);
    #1 chk("idle_no_beats", 64'(log_q.size()), 64'h0);

    // Length 20, bytes 0x01..0x14, full-rate ready
    v = '0;
    for (int i = 0; i < 20; i++) v[8*i +: 8] = 8'(i + 1);
    b = log_q.size();
    send_msg(20, v, 1'b0);
    wait_idle();
    chk_beat("l20_b0", b,     64'h0807060504030201, 8'hFF, 1'b0, 1'b0);
    chk_beat("l20_b1", b + 1, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, 1'b0);
    chk_beat("l20_b2", b + 2, 64'h0000000014131211, 8'h0F, 1'b1, 1'b0);
    if (log_q.size() >= b + 3) begin
      chk("l20_b1_gap", 64'(log_q[b+1].cyc - log_q[b].cyc), 64'd1);
      chk("l20_b2_gap", 64'(log_q[b+2].cyc - log_q[b+1].cyc), 64'd1);
    end

    // Length 16 with error, ready pattern 1,0,0,1
    v = '0;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(i + 8'h30);
    pat.push_back(1'b1); pat.push_back(1'b0); pat.push_back(1'b0); pat.push_back(1'b1);
    b = log_q.size();
    send_msg(16, v, 1'b1);
    wait_idle();
    chk_beat("l16_b0", b,     64'h3736353433323130, 8'hFF, 1'b0, 1'b0);
    chk_beat("l16_b1", b + 1, 64'h3F3E3D3C3B3A3938, 8'hFF, 1'b1, 1'b1);
    if (log_q.size() >= b + 2) chk("l16_stall_gap", 64'(log_q[b+1].cyc - log_q[b].cyc), 64'd3);

    // Length 40 clamps to 32 and flags overflow
    v = '0;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(i);
    b = log_q.size();
    send_msg(40, v, 1'b0);
    wait_idle();
    chk_beat("l40_b0", b,     64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    chk_beat("l40_b3", b + 3, 64'h1F1E1D1C1B1A1918, 8'hFF, 1'b1, 1'b1);
    chk("l40_beats", 64'(log_q.size() - b), 64'd4);

    // Length 0 is discarded, then a length-1 message
    b = log_q.size();
    send_msg(0, v, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("l0_no_beats", 64'(log_q.size() - b), 64'd0);
    v = '0;
    v[7:0] = 8'hAA;
    send_msg(1, v, 1'b0);
    wait_idle();
    chk_beat("l1_b0", b, 64'h00000000000000AA, 8'h01, 1'b1, 1'b0);

    // Reset while beat 2 of a 4-beat message is on the bus
    v = '0;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(8'h80 + i);
    b = log_q.size();
    send_msg(32, v, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_tvalid", {63'h0, m_tvalid}, 64'h0);
    chk("midrst_msg_ready", {63'h0, msg_ready}, 64'h1);
    chk("midrst_beats", 64'(log_q.size() - b), 64'd1);
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(8'h51 + i);
    b = log_q.size();
    send_msg(8, v, 1'b0);
    wait_idle();
    chk_beat("post_rst_b0", b, 64'h5857565554535251, 8'hFF, 1'b1, 1'b0);

    // Randomized traffic with random backpressure
    rdy_mode = 0;
    for (int n = 0; n < 150; n++) begin
      for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
      len = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 40));
      send_msg(len, v, 1'($urandom % 2));
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_serializer.md
Name: msg_serializer

Overview:
- Transmit-side counterpart of the team's AXI-Stream message parser.
- Accepts one complete message per handshake (flat byte vector, byte length, error flag) and streams it out as an AXI-Stream master, DATA_BYTES per beat, LSB-first.
- Sits between message-producing logic and any AXI-Stream sink. Its output is directly consumable by the parser, so the two blocks loop back byte-exact.

Parameters:
- MAX_MSG_BYTES, 32, maximum message size in bytes; width of msg_data is 8*MAX_MSG_BYTES.
- DATA_BYTES, 8, bytes per AXI-Stream beat; must be ≤ MAX_MSG_BYTES.
- TKEEP_WIDTH, 8, width of m_tkeep; must equal DATA_BYTES.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- msg_valid  input  1  message present on msg_* inputs.
- msg_ready  output  1  block can accept a message.
- msg_length  input  16  message length in bytes.
- msg_data  input  8*MAX_MSG_BYTES  message bytes; byte 0 is on [7:0].
- msg_error  input  1  message is flagged bad; reported on m_tuser.
- m_tvalid  output  1  AXI-Stream beat valid.
- m_tready  input  1  downstream ready.
- m_tdata  output  8*DATA_BYTES  beat data; lowest message byte of the beat is on [7:0].
- m_tkeep  output  TKEEP_WIDTH  byte enables; contiguous from bit 0.
- m_tlast  output  1  final beat of the message.
- m_tuser  output  1  error flag; meaningful only when m_tlast=1, driven 0 otherwise.
- tx_done  output  1  one-cycle pulse when the last beat handshakes.

Behaviour:
- Reset: while rst=1 and on the cycle after it:
  - state=IDLE, msg_ready=1.
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, m_tuser=0, tx_done=0.
  - Internal message register and counters are cleared.
  - Reset asserted mid-message aborts the message immediately. No tlast is emitted.
- States:
  - IDLE: msg_ready=1, m_tvalid=0.
  - SEND: msg_ready=0, m_tvalid=1.
- Acceptance (IDLE with msg_valid=1):
  - Register msg_data, the effective length L, and msg_error.
  - L = min(msg_length, MAX_MSG_BYTES). If msg_length > MAX_MSG_BYTES, set an internal overflow flag.
  - If L=0: the message is consumed and discarded. No beats are sent, tx_done is not pulsed, and the block stays in IDLE with msg_ready=1.
  - Otherwise go to SEND. The first beat is valid on the next cycle (1-cycle latency from acceptance).
- Beat count: N = ceil(L/DATA_BYTES). Beat k (0-based) carries message bytes k*DATA_BYTES .. k*DATA_BYTES+DATA_BYTES-1.
- m_tkeep:
  - Non-final beats: all ones.
  - Final beat with R = L mod DATA_BYTES: (1<<R)-1 if R≠0, else all ones.
  - Bytes with tkeep=0 are driven 0 in m_tdata.
- m_tlast=1 only on beat N-1.
- m_tuser on the final beat = registered msg_error OR overflow flag.
- AXI-Stream hold rule: while m_tvalid=1 and m_tready=0, m_tdata, m_tkeep, m_tlast and m_tuser hold stable. m_tvalid never deasserts before its handshake.
- Beat advance: each cycle with m_tvalid && m_tready, advance to the next beat. Back-to-back beats run at full rate when m_tready stays 1.
- Final-beat handshake:
  - tx_done=1 for that cycle.
  - The next cycle is IDLE with msg_ready=1.
  - Message-to-message throughput is N+1 cycles minimum (one idle bubble).
- Flow control: msg_valid while in SEND is ignored; the producer holds its message until msg_ready. m_tready asserted while in IDLE has no effect.
- Beat index counter width: clog2(ceil(MAX_MSG_BYTES/DATA_BYTES))+1. No wrap is possible because L ≤ MAX_MSG_BYTES.

Test Plan:
- Reset, then idle → msg_ready=1, m_tvalid=0, all m_* outputs 0; msg_valid=0 produces no beats.
- Length 20, bytes 0x01..0x14, no error, m_tready=1 → 3 beats on consecutive cycles:
  - m_tdata 0x0807060504030201, 0x100F0E0D0C0B0A09, 0x0000000014131211.
  - m_tkeep 0xFF, 0xFF, 0x0F; m_tlast only on beat 3; m_tuser=0; tx_done on beat 3.
  - msg_ready returns 1 on the next cycle.
- Length 16 with msg_error=1, m_tready toggling 1,0,0,1 → 2 beats, each held stable through stalls; beat 2 has m_tkeep=0xFF, m_tlast=1, m_tuser=1.
- Length 40 (exceeds 32) → 4 full beats carrying bytes 0..31; final m_tkeep=0xFF, m_tlast=1, m_tuser=1.
- Length 0 → no m_tvalid, no tx_done, msg_ready stays 1; a following length-1 message (byte 0xAA) gives one beat: m_tdata=0x00000000000000AA, m_tkeep=0x01, m_tlast=1.
- Reset asserted during beat 2 of a 4-beat message → next cycle m_tvalid=0, msg_ready=1; a new length-8 message then sends one clean beat with m_tkeep=0xFF, m_tlast=1.
